// File: rtl/acq_scan_fsm.sv
// Acquisition scan FSM: walks the pixel array (row inner, column outer), settles,
// converts one ADC sample per pixel and writes it raw into frame RAM.
module acq_scan_fsm #(
    parameter int PIXEL_N_COLS   = 24,
    parameter int PIXEL_N_ROWS   = 24,
    parameter int NB_ADC         = 12,
    parameter int NB_ADDR        = 10,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_rdy,
    output logic               o_err,
    output logic [4:0]         o_row_sel,
    output logic [4:0]         o_col_sel,
    output logic               o_adc_start,
    input  logic               i_adc_valid,
    input  logic [NB_ADC-1:0]  i_adc_data,
    output logic               o_ram_write,
    output logic [NB_ADDR-1:0] o_ram_addr,
    output logic [NB_ADC-1:0]  o_ram_value
);

    typedef enum logic [3:0] {
        IDLE, SELECT, SETTLE, CONVERT, WAIT_ADC, WRITE, NEXT, DONE, ERROR
    } state_t;

    localparam logic [4:0]         LAST_ROW    = 5'(PIXEL_N_ROWS - 1);
    localparam logic [4:0]         LAST_COL    = 5'(PIXEL_N_COLS - 1);
    localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [9:0]         TMO_LIMIT   = 10'(TIMEOUT_CYCLES);
    localparam logic [NB_ADDR-1:0] COLS_A      = NB_ADDR'(PIXEL_N_COLS);

    state_t              state_q, state_d;
    logic [4:0]          row_q, row_d;
    logic [4:0]          col_q, col_d;
    logic [7:0]          settle_q, settle_d;
    logic [9:0]          tmo_q, tmo_d;
    logic [NB_ADC-1:0]   cap_q, cap_d;
    logic                err_d;
    logic [NB_ADDR-1:0]  pix_addr;

    assign pix_addr = NB_ADDR'(row_q) * COLS_A + NB_ADDR'(col_q);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        cap_d    = cap_q;
        err_d    = o_err;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    err_d   = 1'b0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                settle_d = 8'd0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                settle_d = settle_q + 8'd1;
                if (settle_q == SETTLE_LAST) state_d = CONVERT;
            end
            CONVERT: begin
                tmo_d   = 10'd0;
                state_d = WAIT_ADC;
            end
            WAIT_ADC: begin
                // A valid result beats a timeout landing on the same cycle.
                if (i_adc_valid) begin
                    cap_d   = i_adc_data;
                    state_d = WRITE;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                    if (tmo_q + 10'd1 == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end
                end
            end
            WRITE: state_d = NEXT;
            NEXT: begin
                if (row_q < LAST_ROW) begin
                    row_d   = row_q + 5'd1;
                    state_d = SELECT;
                end else begin
                    row_d = 5'd0;
                    if (col_q < LAST_COL) begin
                        col_d   = col_q + 5'd1;
                        state_d = SELECT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                row_d   = 5'd0;
                col_d   = 5'd0;
                state_d = IDLE;
            end
            ERROR: begin
                // Row/column stay frozen here so the failing pixel can be inspected.
                if (i_start) begin
                    err_d   = 1'b0;
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                    state_d = SELECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are valid during that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= 5'd0;
            col_q       <= 5'd0;
            settle_q    <= 8'd0;
            tmo_q       <= 10'd0;
            cap_q       <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_rdy       <= 1'b0;
            o_adc_start <= 1'b0;
            o_ram_write <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_value <= '0;
            o_row_sel   <= 5'd0;
            o_col_sel   <= 5'd0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            settle_q    <= settle_d;
            tmo_q       <= tmo_d;
            cap_q       <= cap_d;
            o_err       <= err_d;
            o_busy      <= !(state_d inside {IDLE, DONE, ERROR});
            o_rdy       <= (state_d == DONE);
            o_adc_start <= (state_d == CONVERT);
            o_ram_write <= (state_d == WRITE);
            o_ram_addr  <= (state_d == WRITE) ? pix_addr : '0;
            o_ram_value <= (state_d == WRITE) ? cap_d : '0;
            if (state_d == SELECT) begin
                o_row_sel <= row_d;
                o_col_sel <= col_d;
            end
        end
    end

endmodule

// File: tb/tb_acq_scan_fsm.sv
// Directed bench for acq_scan_fsm: default 24x24 array plus a 2x2 instance for scan order.
`timescale 1ns/1ps
module tb_acq_scan_fsm;

    localparam int ROWS = 24;
    localparam int COLS = 24;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, rdy, err, adcStart, ramWrite, adcValid;
    logic [4:0]  rowSel, colSel;
    logic [11:0] adcData, ramValue;
    logic [9:0]  ramAddr;

    logic sStart, sBusy, sRdy, sErr, sAdcStart, sWrite, sValid;
    logic [4:0]  sRowSel, sColSel;
    logic [11:0] sData, sValue;
    logic [9:0]  sAddr;

    int   adcSkip = -1;
    int   adcSlowPix = -1;
    int   adcSlowDelay = 1;
    int   adcCnt = 0;
    int   sCnt = 0;
    logic modelValid = 1'b0;
    logic forceValid = 1'b0;

    assign adcValid = modelValid | forceValid;

    always #5 clk = ~clk;

    acq_scan_fsm dut (
        .clk(clk), .rst(rst), .i_start(start),
        .o_busy(busy), .o_rdy(rdy), .o_err(err),
        .o_row_sel(rowSel), .o_col_sel(colSel),
        .o_adc_start(adcStart), .i_adc_valid(adcValid), .i_adc_data(adcData),
        .o_ram_write(ramWrite), .o_ram_addr(ramAddr), .o_ram_value(ramValue)
    );

    acq_scan_fsm #(.PIXEL_N_COLS(2), .PIXEL_N_ROWS(2)) dutSmall (
        .clk(clk), .rst(rst), .i_start(sStart),
        .o_busy(sBusy), .o_rdy(sRdy), .o_err(sErr),
        .o_row_sel(sRowSel), .o_col_sel(sColSel),
        .o_adc_start(sAdcStart), .i_adc_valid(sValid), .i_adc_data(sData),
        .o_ram_write(sWrite), .o_ram_addr(sAddr), .o_ram_value(sValue)
    );

    // ADC model: answers after a per-pixel number of WAIT cycles (0 = never) with data = address.
    always @(negedge clk) begin : adcModel
        int pix, delay;
        pix     = int'(colSel) * ROWS + int'(rowSel);
        delay   = (pix == adcSkip) ? 0 : ((pix == adcSlowPix) ? adcSlowDelay : 1);
        adcData = 12'(int'(rowSel) * COLS + int'(colSel));
        if (adcStart) begin
            adcCnt = delay;
            modelValid = 1'b0;
        end else if (adcCnt > 0) begin
            adcCnt = adcCnt - 1;
            modelValid = (adcCnt == 0);
        end else begin
            modelValid = 1'b0;
        end
    end

    always @(negedge clk) begin : smallAdcModel
        sData = 12'(int'(sRowSel) * 2 + int'(sColSel));
        if (sAdcStart) begin
            sCnt = 1;
            sValid = 1'b0;
        end else if (sCnt > 0) begin
            sCnt = sCnt - 1;
            sValid = (sCnt == 0);
        end else begin
            sValid = 1'b0;
        end
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sStart = 1'b0; forceValid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, rdy, err, adcStart, ramWrite} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got %b, expected 00000", {busy, rdy, err, adcStart, ramWrite});
        end
        checks++;
        if (rowSel !== 5'd0 || colSel !== 5'd0) begin
            errors++; $display("[TB] FAIL reset_sel: got %0d/%0d, expected 0/0", rowSel, colSel);
        end
        checks++;
        if (ramAddr !== 10'd0 || ramValue !== 12'd0) begin
            errors++; $display("[TB] FAIL reset_ram: got %0d/%0d, expected 0/0", ramAddr, ramValue);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_full_frame(input bit repulse);
        int wr = 0, bad = 0, rdys = 0, rdyAt = -1, expAddr;
        logic busyMid = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 6000; k++) begin
            @(negedge clk);
            start = (repulse && (k == 2000 || k == 3500)) ? 1'b1 : 1'b0;
            if (k == 1000) busyMid = busy;
            if (ramWrite) begin
                expAddr = (wr % ROWS) * COLS + wr / ROWS;
                if (ramAddr !== 10'(expAddr) || ramValue !== 12'(expAddr)) bad++;
                wr++;
            end
            if (rdy) begin
                rdys++;
                if (rdyAt < 0) rdyAt = k;
            end
            if (rdyAt >= 0 && k >= rdyAt + 5) break;
        end
        start = 1'b0;
        checks++;
        if (rdyAt != 5185) begin
            errors++; $display("[TB] FAIL frame_rdy_cycle(repulse=%0d): got %0d, expected 5185", repulse, rdyAt);
        end
        checks++;
        if (rdys != 1) begin
            errors++; $display("[TB] FAIL frame_rdy_count(repulse=%0d): got %0d, expected 1", repulse, rdys);
        end
        checks++;
        if (wr != 576) begin
            errors++; $display("[TB] FAIL frame_writes(repulse=%0d): got %0d, expected 576", repulse, wr);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("[TB] FAIL frame_addr_value(repulse=%0d): got %0d bad writes, expected 0", repulse, bad);
        end
        checks++;
        if (busyMid !== 1'b1) begin
            errors++; $display("[TB] FAIL frame_busy_mid: got %b, expected 1", busyMid);
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL frame_end_flags: got err=%b busy=%b, expected 0/0", err, busy);
        end
    endtask

    task automatic test_timeout();
        int wr = 0, errAt = -1, lateWr = 0, firstAt = -1;
        logic [9:0] firstAddr = '1;
        adcSkip = 3;
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (ramWrite) wr++;
            if (err) begin errAt = k; break; end
        end
        checks++;
        if (errAt != 98) begin
            errors++; $display("[TB] FAIL timeout_cycle: got %0d, expected 98", errAt);
        end
        checks++;
        if (wr != 3) begin
            errors++; $display("[TB] FAIL timeout_writes: got %0d, expected 3", wr);
        end
        checks++;
        if (rowSel !== 5'd3 || colSel !== 5'd0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_sel: got %0d/%0d busy=%b, expected 3/0 busy=0", rowSel, colSel, busy);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            forceValid = (k == 5);
            if (ramWrite) lateWr++;
        end
        forceValid = 1'b0;
        checks++;
        if (err !== 1'b1 || lateWr != 0 || rowSel !== 5'd3 || colSel !== 5'd0) begin
            errors++; $display("[TB] FAIL error_sticky: got err=%b writes=%0d sel=%0d/%0d, expected 1/0/3/0", err, lateWr, rowSel, colSel);
        end
        adcSkip = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || rowSel !== 5'd0) begin
            errors++; $display("[TB] FAIL error_restart: got err=%b busy=%b row=%0d, expected 0/1/0", err, busy, rowSel);
        end
        for (int k = 2; k <= 50; k++) begin
            @(negedge clk);
            if (ramWrite) begin firstAt = k; firstAddr = ramAddr; break; end
        end
        checks++;
        if (firstAt != 8 || firstAddr !== 10'd0) begin
            errors++; $display("[TB] FAIL rescan_first_write: got cycle %0d addr %0d, expected 8/0", firstAt, firstAddr);
        end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_timeout_limit();
        int wAt = -1, w2At = -1;
        logic errSeen = 1'b0;
        logic [9:0] wAddr = '1, w2Addr = '1;
        adcSlowPix = 0; adcSlowDelay = 64;
        start = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (err) errSeen = 1'b1;
            if (ramWrite && wAt < 0) begin wAt = k; wAddr = ramAddr; end
            else if (ramWrite) begin w2At = k; w2Addr = ramAddr; break; end
        end
        checks++;
        if (wAt != 71 || errSeen !== 1'b0 || wAddr !== 10'd0) begin
            errors++; $display("[TB] FAIL valid_at_limit: got cycle %0d err=%b addr=%0d, expected 71/0/0", wAt, errSeen, wAddr);
        end
        checks++;
        if (w2At != 80 || w2Addr !== 10'd24) begin
            errors++; $display("[TB] FAIL after_limit_next: got cycle %0d addr %0d, expected 80/24", w2At, w2Addr);
        end
        adcSlowPix = -1;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_spurious_valid();
        int wr = 0, errAt = -1;
        adcSkip = 0;
        start = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            start = 1'b0;
            forceValid = (k >= 2 && k <= 6);
            if (ramWrite) wr++;
            if (err) begin errAt = k; break; end
        end
        forceValid = 1'b0;
        checks++;
        if (wr != 0 || errAt != 71) begin
            errors++; $display("[TB] FAIL spurious_valid: got writes=%0d err_cycle=%0d, expected 0/71", wr, errAt);
        end
        adcSkip = -1;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int wr = 0, lateWr = 0, lateRdy = 0, firstAt = -1;
        logic [9:0] firstAddr = '1;
        start = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (ramWrite) wr++;
            if (wr == 100) break;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rdy, err, adcStart, ramWrite} !== 5'b0 || rowSel !== 5'd0 || colSel !== 5'd0
            || ramAddr !== 10'd0 || ramValue !== 12'd0) begin
            errors++; $display("[TB] FAIL mid_reset_outputs: got flags=%b sel=%0d/%0d ram=%0d/%0d, expected all 0",
                               {busy, rdy, err, adcStart, ramWrite}, rowSel, colSel, ramAddr, ramValue);
        end
        rst = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (ramWrite) lateWr++;
            if (rdy) lateRdy++;
        end
        checks++;
        if (lateWr != 0 || lateRdy != 0) begin
            errors++; $display("[TB] FAIL mid_reset_quiet: got writes=%0d rdy=%0d, expected 0/0", lateWr, lateRdy);
        end
        start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (ramWrite) begin firstAt = k; firstAddr = ramAddr; break; end
        end
        checks++;
        if (firstAt != 8 || firstAddr !== 10'd0) begin
            errors++; $display("[TB] FAIL mid_reset_restart: got cycle %0d addr %0d, expected 8/0", firstAt, firstAddr);
        end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_small_array();
        int startAt[4] = '{6, 15, 24, 33};
        int addrExp[4] = '{0, 2, 1, 3};
        int rowExp[4]  = '{0, 1, 0, 1};
        int colExp[4]  = '{0, 0, 1, 1};
        int ns = 0, nw = 0, badStart = 0, badWrite = 0, rdyAt = -1;
        sStart = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            sStart = 1'b0;
            if (sAdcStart) begin
                if (ns >= 4 || startAt[ns < 4 ? ns : 0] != k) badStart++;
                ns++;
            end
            if (sWrite) begin
                if (nw >= 4) badWrite++;
                else if (sAddr !== 10'(addrExp[nw]) || sValue !== 12'(addrExp[nw])
                         || sRowSel !== 5'(rowExp[nw]) || sColSel !== 5'(colExp[nw])) badWrite++;
                nw++;
            end
            if (sRdy && rdyAt < 0) rdyAt = k;
            if (rdyAt >= 0 && k >= rdyAt + 2) break;
        end
        checks++;
        if (ns != 4 || badStart != 0) begin
            errors++; $display("[TB] FAIL small_adc_start: got %0d starts %0d off-cycle, expected 4/0", ns, badStart);
        end
        checks++;
        if (nw != 4 || badWrite != 0) begin
            errors++; $display("[TB] FAIL small_write_order: got %0d writes %0d wrong, expected 4/0", nw, badWrite);
        end
        checks++;
        if (rdyAt != 37 || sBusy !== 1'b0 || sErr !== 1'b0) begin
            errors++; $display("[TB] FAIL small_done: got rdy cycle %0d busy=%b err=%b, expected 37/0/0", rdyAt, sBusy, sErr);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame(1'b0);
        test_timeout();
        test_timeout_limit();
        test_spurious_valid();
        test_reset_mid_frame();
        test_full_frame(1'b1);
        test_small_array();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_scan_fsm.md
Name: acq_scan_fsm

Overview:
- Acquisition stage directly upstream of the pixel de-accumulation FSM.
- Scans the full PIXEL_N_ROWS x PIXEL_N_COLS sensor array: selects each pixel, waits for analog settling, triggers one ADC conversion, and writes the raw (still accumulated) sample into frame RAM.
- Its o_rdy pulse is the i_start of the de-accumulation stage.

Parameters:
- PIXEL_N_COLS, 24, sensor columns.
- PIXEL_N_ROWS, 24, sensor rows.
- NB_ADC, 12, ADC sample width.
- NB_ADDR, 10, RAM address width; must satisfy 2^NB_ADDR >= PIXEL_N_ROWS*PIXEL_N_COLS.
- SETTLE_CYCLES, 4, clock cycles between pixel select and conversion start (1..255).
- TIMEOUT_CYCLES, 64, maximum WAIT_ADC cycles before the error state (1..1023).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_start  in  1  start a frame scan; honoured only in IDLE or ERROR.
- o_busy  out  1  high in every state except IDLE, DONE and ERROR.
- o_rdy  out  1  one-cycle pulse: frame fully written.
- o_err  out  1  ADC timeout flag; sticky.
- o_row_sel  out  5  row select to pixel array.
- o_col_sel  out  5  column select to pixel array.
- o_adc_start  out  1  one-cycle conversion request.
- i_adc_valid  in  1  conversion result valid.
- i_adc_data  in  NB_ADC  conversion result.
- o_ram_write  out  1  RAM write enable.
- o_ram_addr  out  NB_ADDR  RAM address = row*PIXEL_N_COLS + col.
- o_ram_value  out  NB_ADC  sample to write.

Behaviour:
- Reset values:
  - state = IDLE.
  - row = col = 0.
  - All outputs 0, o_err included.
  - Capture register cleared.
- States: IDLE, SELECT, SETTLE, CONVERT, WAIT_ADC, WRITE, NEXT, DONE, ERROR.
- IDLE: on i_start -> SELECT; o_err cleared in the same cycle.
- SELECT (1 cycle):
  - o_row_sel/o_col_sel driven from the registered row/col counters.
  - The selects hold these values in all states until the next NEXT.
  - Settle counter loaded with 0.
  - -> SETTLE.
- SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles in SETTLE -> CONVERT.
- CONVERT (1 cycle):
  - o_adc_start = 1; timeout counter cleared.
  - -> WAIT_ADC.
  - i_adc_valid is ignored in every state except WAIT_ADC.
- WAIT_ADC:
  - If i_adc_valid is high, capture i_adc_data -> WRITE.
  - Else increment the timeout counter; when it reaches TIMEOUT_CYCLES -> ERROR.
  - Valid and the timeout reaching its limit in the same cycle: valid wins.
- WRITE (1 cycle):
  - o_ram_write = 1.
  - o_ram_addr = row*PIXEL_N_COLS + col, computed combinationally from the counters, zero-extended to NB_ADDR.
  - o_ram_value = captured sample, unmodified.
  - o_ram_write is 0 in every other state.
- NEXT (scan order is row inner, column outer):
  - If row < PIXEL_N_ROWS-1: row++ -> SELECT.
  - Else row = 0 and, if col < PIXEL_N_COLS-1, col++ -> SELECT.
  - Else (last pixel) -> DONE.
- DONE (1 cycle):
  - o_rdy = 1; row = col = 0.
  - -> IDLE.
  - i_start is ignored in DONE.
- ERROR:
  - o_err = 1, sticky; row/col frozen for debug; o_busy = 0.
  - On i_start: o_err cleared, row = col = 0 -> SELECT.
- Per-pixel latency with valid in the first WAIT_ADC cycle: 1 + SETTLE_CYCLES + 1 + 1 + 1 + 1 = SETTLE_CYCLES+5 cycles.
- Frame latency, i_start to o_rdy: 1 + N*(SETTLE_CYCLES+5) cycles, where N = PIXEL_N_ROWS*PIXEL_N_COLS.
  - Defaults: 1 + 576*9 = 5185 cycles.
- i_start while busy: ignored, scan unaffected.
- rst mid-frame: returns to the full reset state on the next edge; no further RAM writes; no o_rdy.
- An i_adc_valid pulse arriving after a timeout is ignored.

Test Plan:
- Defaults, 1-cycle i_start, ADC model returns valid 1 cycle after o_adc_start with data = addr -> 576 writes, addresses 0..575, each value = its address; o_rdy once at cycle 5185 after start; o_err = 0.
- PIXEL_N_ROWS=PIXEL_N_COLS=2 -> write address order 0,2,1,3 (row inner); selects (r,c) = (0,0),(1,0),(0,1),(1,1); o_adc_start exactly SETTLE_CYCLES+1 cycles after each SELECT.
- ADC never responds at pixel 3 -> o_err = 1 after 64 WAIT_ADC cycles; exactly 3 writes; row_sel = 3, col_sel = 0 held; then i_start -> o_err = 0 and rescan begins at address 0.
- Valid asserted on the timeout-limit cycle -> WRITE taken, no error; valid pulses during SETTLE/CONVERT -> no capture, no write.
- i_start re-pulsed mid-frame -> ignored; total writes still 576, o_rdy single pulse.
- rst asserted at pixel 100 -> next cycle: state IDLE, all outputs 0; no further writes; a fresh i_start restarts at address 0.
